// File: rtl/ctl_duck_motion.sv
`default_nettype none
// ============================================================================
// Module   : ctl_duck_motion
// Purpose  : Duck position controller: launch, bounce, fly-away, hit and fall.
// Revision : 1.0 - initial release
// ============================================================================
module ctl_duck_motion #(
    parameter int SCREEN_W      = 1024,
    parameter int SCREEN_H      = 768,
    parameter int POS_W         = 11,
    parameter int SPD_W         = 5,
    parameter int CNT_W         = 5,
    parameter int DEFAULT_V_SPD = 15,
    parameter int FALL_SPD      = 8,
    parameter int HIT_FRAMES    = 30,
    parameter int FLAP_FRAMES   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             new_frame,
    input  logic             start,
    input  logic             shot_hit,
    input  logic             duck_direction,
    input  logic [CNT_W-1:0] reflections,
    input  logic [SPD_W-1:0] duck_v_spd,
    input  logic [SPD_W-1:0] duck_h_spd,
    input  logic [POS_W-1:0] duck_start_x,
    output logic [POS_W-1:0] duck_x,
    output logic [POS_W-1:0] duck_y,
    output logic             duck_show,
    output logic             duck_hit,
    output logic             duck_flap,
    output logic             duck_escaped,
    output logic [CNT_W-1:0] reflection_cnt,
    output logic             busy,
    output logic             done
);

    localparam int c_HIT_W  = (HIT_FRAMES  > 1) ? $clog2(HIT_FRAMES)  : 1;
    localparam int c_FLAP_W = (FLAP_FRAMES > 1) ? $clog2(FLAP_FRAMES) : 1;

    localparam logic [POS_W:0]    c_MAX_X_E = (POS_W+1)'(SCREEN_W);
    localparam logic [POS_W:0]    c_MAX_Y_E = (POS_W+1)'(SCREEN_H);
    localparam logic [POS_W-1:0]  c_MAX_X   = POS_W'(SCREEN_W);
    localparam logic [POS_W-1:0]  c_MAX_Y   = POS_W'(SCREEN_H);
    localparam logic [POS_W:0]    c_FALL    = (POS_W+1)'(FALL_SPD);
    localparam logic [SPD_W-1:0]  c_DEF_V   = SPD_W'(DEFAULT_V_SPD);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = '1;
    localparam logic [c_HIT_W-1:0]  c_HIT_LAST  = c_HIT_W'(HIT_FRAMES - 1);
    localparam logic [c_FLAP_W-1:0] c_FLAP_LAST = c_FLAP_W'(FLAP_FRAMES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FLY      = 3'd1,
        S_FLY_AWAY = 3'd2,
        S_HIT      = 3'd3,
        S_FALL     = 3'd4
    } state_t;

    state_t              r_state;
    logic [POS_W-1:0]    r_x;
    logic [POS_W-1:0]    r_y;
    logic                r_dir_right;
    logic                r_dir_down;
    logic [SPD_W-1:0]    r_v_spd;
    logic [SPD_W-1:0]    r_h_spd;
    logic [CNT_W-1:0]    r_target;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_FLAP_W-1:0] r_flap_cnt;
    logic [c_HIT_W-1:0]  r_hit_cnt;
    logic                r_show;
    logic                r_hit;
    logic                r_flap;
    logic                r_escaped;
    logic                r_busy;
    logic                r_done;

    logic [POS_W:0]      w_x_ext;
    logic [POS_W:0]      w_y_ext;
    logic [POS_W:0]      w_h_ext;
    logic [POS_W:0]      w_v_ext;
    logic [POS_W:0]      w_x_add;
    logic [POS_W:0]      w_y_add;
    logic [POS_W:0]      w_y_fall;
    logic [POS_W-1:0]    w_x_sub;
    logic [POS_W-1:0]    w_y_sub;
    logic [POS_W-1:0]    w_x_nxt;
    logic [POS_W-1:0]    w_y_nxt;
    logic [POS_W-1:0]    w_start_x;
    logic                w_dir_right_nxt;
    logic                w_dir_down_nxt;
    logic                w_x_clamp;
    logic                w_y_clamp;
    logic                w_top_out;
    logic                w_fall_end;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [c_FLAP_W-1:0] w_flap_cnt_nxt;
    logic                w_flap_nxt;

    // Arithmetic is one bit wider than the position so edge overshoot is visible.
    always_comb begin
        w_x_ext         = {1'b0, r_x};
        w_y_ext         = {1'b0, r_y};
        w_h_ext         = (POS_W+1)'(r_h_spd);
        w_v_ext         = (POS_W+1)'(r_v_spd);
        w_x_add         = w_x_ext + w_h_ext;
        w_y_add         = w_y_ext + w_v_ext;
        w_y_fall        = w_y_ext + c_FALL;
        w_x_sub         = r_x - POS_W'(r_h_spd);
        w_y_sub         = r_y - POS_W'(r_v_spd);
        w_top_out       = (w_y_ext < w_v_ext);
        w_fall_end      = (w_y_fall >= c_MAX_Y_E);
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_dir_right_nxt = r_dir_right;
        w_dir_down_nxt  = r_dir_down;
        w_x_clamp       = 1'b0;
        w_y_clamp       = 1'b0;

        if (r_dir_right) begin
            if (w_x_add > c_MAX_X_E) begin
                w_x_nxt         = c_MAX_X;
                w_dir_right_nxt = 1'b0;
                w_x_clamp       = 1'b1;
            end else begin
                w_x_nxt = w_x_add[POS_W-1:0];
            end
        end else begin
            if (w_x_ext < w_h_ext) begin
                w_x_nxt         = '0;
                w_dir_right_nxt = 1'b1;
                w_x_clamp       = 1'b1;
            end else begin
                w_x_nxt = w_x_sub;
            end
        end

        if (r_dir_down) begin
            if (w_y_add > c_MAX_Y_E) begin
                w_y_nxt        = c_MAX_Y;
                w_dir_down_nxt = 1'b0;
                w_y_clamp      = 1'b1;
            end else begin
                w_y_nxt = w_y_add[POS_W-1:0];
            end
        end else begin
            if (w_top_out) begin
                w_y_nxt        = '0;
                w_dir_down_nxt = 1'b1;
                w_y_clamp      = 1'b1;
            end else begin
                w_y_nxt = w_y_sub;
            end
        end

        w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

        if (r_flap_cnt == c_FLAP_LAST) begin
            w_flap_cnt_nxt = '0;
            w_flap_nxt     = ~r_flap;
        end else begin
            w_flap_cnt_nxt = r_flap_cnt + 1'b1;
            w_flap_nxt     = r_flap;
        end

        w_start_x = ({1'b0, duck_start_x} > c_MAX_X_E) ? c_MAX_X : duck_start_x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_dir_right <= 1'b0;
            r_dir_down  <= 1'b0;
            r_v_spd     <= '0;
            r_h_spd     <= '0;
            r_target    <= '0;
            r_cnt       <= '0;
            r_flap_cnt  <= '0;
            r_hit_cnt   <= '0;
            r_show      <= 1'b0;
            r_hit       <= 1'b0;
            r_flap      <= 1'b0;
            r_escaped   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x         <= w_start_x;
                        r_y         <= c_MAX_Y;
                        r_v_spd     <= (duck_v_spd == '0) ? c_DEF_V : duck_v_spd;
                        r_h_spd     <= duck_h_spd;
                        r_target    <= reflections;
                        r_dir_right <= duck_direction;
                        r_dir_down  <= 1'b0;
                        r_cnt       <= '0;
                        r_escaped   <= 1'b0;
                        r_flap      <= 1'b0;
                        r_flap_cnt  <= '0;
                        r_show      <= 1'b1;
                        r_hit       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= (reflections == '0) ? S_FLY_AWAY : S_FLY;
                    end
                end

                S_FLY: begin
                    if (shot_hit) begin
                        r_state   <= S_HIT;
                        r_hit     <= 1'b1;
                        r_flap    <= 1'b0;
                        r_hit_cnt <= '0;
                    end else if (new_frame) begin
                        r_x         <= w_x_nxt;
                        r_y         <= w_y_nxt;
                        r_dir_right <= w_dir_right_nxt;
                        r_dir_down  <= w_dir_down_nxt;
                        r_flap      <= w_flap_nxt;
                        r_flap_cnt  <= w_flap_cnt_nxt;
                        // A corner touches both walls but counts once.
                        if (w_x_clamp || w_y_clamp) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == r_target) begin
                                r_state <= S_FLY_AWAY;
                            end
                        end
                    end
                end

                S_FLY_AWAY: begin
                    if (shot_hit) begin
                        r_state   <= S_HIT;
                        r_hit     <= 1'b1;
                        r_flap    <= 1'b0;
                        r_hit_cnt <= '0;
                    end else if (new_frame) begin
                        if (w_top_out) begin
                            r_y       <= '0;
                            r_show    <= 1'b0;
                            r_escaped <= 1'b1;
                            r_flap    <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_y        <= w_y_sub;
                            r_flap     <= w_flap_nxt;
                            r_flap_cnt <= w_flap_cnt_nxt;
                        end
                    end
                end

                S_HIT: begin
                    if (new_frame) begin
                        if (r_hit_cnt == c_HIT_LAST) begin
                            r_state <= S_FALL;
                        end else begin
                            r_hit_cnt <= r_hit_cnt + 1'b1;
                        end
                    end
                end

                S_FALL: begin
                    if (new_frame) begin
                        if (w_fall_end) begin
                            r_y     <= c_MAX_Y;
                            r_show  <= 1'b0;
                            r_hit   <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_y <= w_y_fall[POS_W-1:0];
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_show  <= 1'b0;
                    r_hit   <= 1'b0;
                    r_flap  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign duck_x         = r_x;
    assign duck_y         = r_y;
    assign duck_show      = r_show;
    assign duck_hit       = r_hit;
    assign duck_flap      = r_flap;
    assign duck_escaped   = r_escaped;
    assign reflection_cnt = r_cnt;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ctl_duck_motion.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctl_duck_motion
// Purpose  : Directed vector table plus hand sequences for ctl_duck_motion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctl_duck_motion;

    logic        clk;
    logic        rst_n;
    logic        new_frame;
    logic        start;
    logic        shot_hit;
    logic        duck_direction;
    logic [4:0]  reflections;
    logic [4:0]  duck_v_spd;
    logic [4:0]  duck_h_spd;
    logic [10:0] duck_start_x;
    logic [10:0] duck_x;
    logic [10:0] duck_y;
    logic        duck_show;
    logic        duck_hit;
    logic        duck_flap;
    logic        duck_escaped;
    logic [4:0]  reflection_cnt;
    logic        busy;
    logic        done;

    int n_assert;
    int n_fail;

    ctl_duck_motion dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .new_frame      (new_frame),
        .start          (start),
        .shot_hit       (shot_hit),
        .duck_direction (duck_direction),
        .reflections    (reflections),
        .duck_v_spd     (duck_v_spd),
        .duck_h_spd     (duck_h_spd),
        .duck_start_x   (duck_start_x),
        .duck_x         (duck_x),
        .duck_y         (duck_y),
        .duck_show      (duck_show),
        .duck_hit       (duck_hit),
        .duck_flap      (duck_flap),
        .duck_escaped   (duck_escaped),
        .reflection_cnt (reflection_cnt),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] sx;
        logic        dir;
        logic [4:0]  v;
        logic [4:0]  h;
        logic [4:0]  refl;
        logic [10:0] lx;
        logic [10:0] fx;
        logic [10:0] fy;
        logic [4:0]  fcnt;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick_frame();
        @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
    endtask

    task automatic frames(input int n);
        repeat (n) tick_frame();
    endtask

    task automatic go(input logic [10:0] sx, input logic dir, input logic [4:0] v,
                      input logic [4:0] h, input logic [4:0] refl);
        duck_start_x   = sx;
        duck_direction = dir;
        duck_v_spd     = v;
        duck_h_spd     = h;
        reflections    = refl;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int nf;
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0; new_frame = 1'b0; start = 1'b0; shot_hit = 1'b0;
        duck_direction = 1'b0; reflections = '0; duck_v_spd = '0;
        duck_h_spd = '0; duck_start_x = '0;

        //          sx    dir v   h   refl lx    fx    fy   fcnt
        vecs[0] = '{11'd500,  1'b1, 5'd0,  5'd7,  5'd3, 11'd500,  11'd507,  11'd753, 5'd0};
        vecs[1] = '{11'd2000, 1'b1, 5'd5,  5'd7,  5'd3, 11'd1024, 11'd1024, 11'd763, 5'd1};
        vecs[2] = '{11'd3,    1'b0, 5'd15, 5'd7,  5'd3, 11'd3,    11'd0,    11'd753, 5'd1};
        vecs[3] = '{11'd7,    1'b0, 5'd15, 5'd7,  5'd3, 11'd7,    11'd0,    11'd753, 5'd0};
        vecs[4] = '{11'd1017, 1'b1, 5'd15, 5'd7,  5'd3, 11'd1017, 11'd1024, 11'd753, 5'd0};
        vecs[5] = '{11'd500,  1'b1, 5'd15, 5'd7,  5'd0, 11'd500,  11'd500,  11'd753, 5'd0};
        vecs[6] = '{11'd3,    1'b0, 5'd15, 5'd7,  5'd1, 11'd3,    11'd0,    11'd753, 5'd1};
        vecs[7] = '{11'd1024, 1'b1, 5'd31, 5'd31, 5'd3, 11'd1024, 11'd1024, 11'd737, 5'd1};

        #12;
        chk("reset_x", 32'(duck_x), 0);
        chk("reset_y", 32'(duck_y), 0);
        chk("reset_show", 32'(duck_show), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            do_reset();
            go(vecs[i].sx, vecs[i].dir, vecs[i].v, vecs[i].h, vecs[i].refl);
            chk($sformatf("v%0d_launch_x", i), 32'(duck_x), 32'(vecs[i].lx));
            chk($sformatf("v%0d_launch_y", i), 32'(duck_y), 768);
            chk($sformatf("v%0d_launch_show", i), 32'(duck_show), 1);
            chk($sformatf("v%0d_launch_busy", i), 32'(busy), 1);
            chk($sformatf("v%0d_launch_cnt", i), 32'(reflection_cnt), 0);
            tick_frame();
            chk($sformatf("v%0d_frame_x", i), 32'(duck_x), 32'(vecs[i].fx));
            chk($sformatf("v%0d_frame_y", i), 32'(duck_y), 32'(vecs[i].fy));
            chk($sformatf("v%0d_frame_cnt", i), 32'(reflection_cnt), 32'(vecs[i].fcnt));
            chk($sformatf("v%0d_frame_show", i), 32'(duck_show), 1);
        end

        // Wing flap phase over the first sixteen frames.
        do_reset();
        go(11'd500, 1'b1, 5'd0, 5'd7, 5'd3);
        frames(7);
        chk("flap_f7", 32'(duck_flap), 0);
        tick_frame();
        chk("flap_f8", 32'(duck_flap), 1);
        chk("flap_f8_x", 32'(duck_x), 556);
        chk("flap_f8_y", 32'(duck_y), 648);
        frames(8);
        chk("flap_f16", 32'(duck_flap), 0);

        // Top and bottom bounce.
        do_reset();
        go(11'd500, 1'b1, 5'd15, 5'd0, 5'd3);
        frames(51);
        chk("top_pre_y", 32'(duck_y), 3);
        tick_frame();
        chk("top_y", 32'(duck_y), 0);
        chk("top_cnt", 32'(reflection_cnt), 1);
        tick_frame();
        chk("top_next_y", 32'(duck_y), 15);
        frames(50);
        chk("bot_pre_y", 32'(duck_y), 765);
        tick_frame();
        chk("bot_y", 32'(duck_y), 768);
        chk("bot_cnt", 32'(reflection_cnt), 2);
        tick_frame();
        chk("bot_next_y", 32'(duck_y), 753);

        // Corner: both walls in one frame count once.
        do_reset();
        go(11'd663, 1'b1, 5'd15, 5'd7, 5'd3);
        frames(51);
        chk("corner_pre_x", 32'(duck_x), 1020);
        chk("corner_pre_y", 32'(duck_y), 3);
        tick_frame();
        chk("corner_x", 32'(duck_x), 1024);
        chk("corner_y", 32'(duck_y), 0);
        chk("corner_cnt", 32'(reflection_cnt), 1);
        tick_frame();
        chk("corner_next_x", 32'(duck_x), 1017);
        chk("corner_next_y", 32'(duck_y), 15);

        // Fly-away after a single left-wall reflection.
        do_reset();
        go(11'd3, 1'b0, 5'd15, 5'd7, 5'd1);
        frames(2);
        chk("away_x_held", 32'(duck_x), 0);
        chk("away_y", 32'(duck_y), 738);
        frames(49);
        chk("away_pre_y", 32'(duck_y), 3);
        chk("away_pre_show", 32'(duck_show), 1);
        chk("away_pre_done", 32'(done), 0);
        tick_frame();
        chk("away_y0", 32'(duck_y), 0);
        chk("away_show", 32'(duck_show), 0);
        chk("away_escaped", 32'(duck_escaped), 1);
        chk("away_done", 32'(done), 1);
        chk("away_busy", 32'(busy), 0);
        @(negedge clk);
        chk("away_done_pulse", 32'(done), 0);
        chk("away_escaped_hold", 32'(duck_escaped), 1);

        // Hit coincident with a frame, freeze, fall.
        do_reset();
        go(11'd300, 1'b1, 5'd16, 5'd0, 5'd3);
        frames(23);
        chk("hit_pre_y", 32'(duck_y), 400);
        @(negedge clk);
        new_frame = 1'b1;
        shot_hit  = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        shot_hit  = 1'b0;
        chk("hit_x", 32'(duck_x), 300);
        chk("hit_y", 32'(duck_y), 400);
        chk("hit_flag", 32'(duck_hit), 1);
        chk("hit_show", 32'(duck_show), 1);
        go(11'd10, 1'b0, 5'd3, 5'd3, 5'd3);
        chk("hit_start_ignored", 32'(duck_x), 300);
        frames(29);
        chk("hit_f29_y", 32'(duck_y), 400);
        tick_frame();
        chk("hit_f30_y", 32'(duck_y), 400);
        tick_frame();
        chk("fall_y1", 32'(duck_y), 408);
        chk("fall_hit", 32'(duck_hit), 1);
        @(negedge clk);
        shot_hit = 1'b1;
        @(negedge clk);
        shot_hit = 1'b0;
        chk("fall_rehit_y", 32'(duck_y), 408);
        nf = 0;
        for (int k = 0; k < 100; k++) begin
            tick_frame();
            nf++;
            if (done) break;
        end
        chk("fall_frames", 32'(nf), 45);
        chk("fall_done", 32'(done), 1);
        chk("fall_y", 32'(duck_y), 768);
        chk("fall_show", 32'(duck_show), 0);
        chk("fall_hit_clr", 32'(duck_hit), 0);
        chk("fall_escaped", 32'(duck_escaped), 0);
        chk("fall_busy", 32'(busy), 0);
        @(negedge clk);
        shot_hit = 1'b1;
        @(negedge clk);
        shot_hit = 1'b0;
        chk("idle_shot_hit", 32'(duck_hit), 0);
        chk("idle_shot_busy", 32'(busy), 0);

        // Asynchronous reset mid-flight, then relaunch.
        go(11'd500, 1'b1, 5'd0, 5'd7, 5'd3);
        frames(3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_x", 32'(duck_x), 0);
        chk("areset_y", 32'(duck_y), 0);
        chk("areset_show", 32'(duck_show), 0);
        chk("areset_busy", 32'(busy), 0);
        chk("areset_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("areset_post_busy", 32'(busy), 0);
        chk("areset_post_done", 32'(done), 0);
        go(11'd200, 1'b0, 5'd0, 5'd7, 5'd3);
        chk("relaunch_x", 32'(duck_x), 200);
        chk("relaunch_busy", 32'(busy), 1);
        tick_frame();
        chk("relaunch_fx", 32'(duck_x), 193);
        chk("relaunch_fy", 32'(duck_y), 753);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
